// File: rtl/relu_maxpool_nch.sv
// relu_maxpool_nch
//   Post-convolution stage: per-channel optional ReLU followed by a 2x2,
//   stride-2 max pool over a WIDTH x HEIGHT feature map delivered in raster
//   order, NUM_CH channels in parallel.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   valid_in   data_in carries one pixel (all channels); no back-pressure
//   data_in    channel c at [c*DATA_WIDTH +: DATA_WIDTH], signed
//   relu_en    1 = clamp negative samples to 0 (sampled per accepted pixel)
//   frame_clr  synchronous restart of the frame position (wins over valid_in)
//   data_out   pooled pixel, same packing as data_in, held between pulses
//   valid_out  one-cycle pulse per completed 2x2 window
//   done       one-cycle pulse alongside the last pooled pixel of a frame
//
// Handshake: a pixel is accepted on every rising edge where valid_in=1 and
// frame_clr=0; there is no ready. valid_out qualifies data_out for exactly
// the cycle it is high; the consumer must take it then.
module relu_maxpool_nch #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 8,
    parameter int WIDTH      = 16,
    parameter int HEIGHT     = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         valid_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         relu_en,
    input  logic                         frame_clr,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic                         valid_out,
    output logic                         done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int HW = WIDTH / 2;
    localparam int LW = (HW > 1) ? $clog2(HW) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [LW-1:0] lb_idx;
    logic          accept;
    logic          last_col;
    logic          last_row;

    // Per-channel datapath storage. Neither array is reset: every entry is
    // rewritten within a frame before it is read.
    logic signed [DATA_WIDTH-1:0] pair_q  [NUM_CH];
    logic signed [DATA_WIDTH-1:0] linebuf [HW][NUM_CH];

    logic signed [DATA_WIDTH-1:0] relu_v  [NUM_CH];
    logic signed [DATA_WIDTH-1:0] h_max   [NUM_CH];
    logic signed [DATA_WIDTH-1:0] v_max   [NUM_CH];
    logic [NUM_CH*DATA_WIDTH-1:0] pool_flat;

    assign accept   = valid_in && !frame_clr;
    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);
    assign lb_idx   = LW'(col >> 1);

    always_comb begin
        pool_flat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            relu_v[c] = data_in[c*DATA_WIDTH +: DATA_WIDTH];
            if (relu_en && data_in[c*DATA_WIDTH + DATA_WIDTH - 1]) begin
                relu_v[c] = '0;
            end
            // Horizontal max of the stored even-column sample and this one.
            h_max[c] = (pair_q[c] > relu_v[c]) ? pair_q[c] : relu_v[c];
            // Vertical max against the row above, same column pair.
            v_max[c] = (linebuf[lb_idx][c] > h_max[c]) ? linebuf[lb_idx][c] : h_max[c];
            pool_flat[c*DATA_WIDTH +: DATA_WIDTH] = v_max[c];
        end
    end

    // Frame position and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col       <= '0;
            row       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            done      <= 1'b0;
            if (frame_clr) begin
                col <= '0;
                row <= '0;
            end else if (valid_in) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                // Odd row, odd column completes a window.
                if (row[0] && col[0]) begin
                    data_out  <= pool_flat;
                    valid_out <= 1'b1;
                    done      <= last_row && last_col;
                end
            end
        end
    end

    // Pair register and line buffer updates.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!col[0]) begin
                    pair_q[c] <= relu_v[c];
                end else if (!row[0]) begin
                    linebuf[lb_idx][c] <= h_max[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool_nch.sv
// Bench for relu_maxpool_nch: a small instance (2 ch, 16 bit, 4x4) for the
// functional cases and a default instance (8 ch, 32 bit, 16x16) for
// back-to-back frames. An image-level model predicts every output cycle.
module tb_relu_maxpool_nch;

  localparam int A_DW = 16, A_NCH = 2, A_W = 4, A_H = 4;
  localparam int B_DW = 32, B_NCH = 8, B_W = 16, B_H = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  logic                   a_valid, a_relu, a_clr;
  logic [A_NCH*A_DW-1:0]  a_data;
  logic [A_NCH*A_DW-1:0]  a_dout;
  logic                   a_vout, a_done;

  relu_maxpool_nch #(.DATA_WIDTH(A_DW), .NUM_CH(A_NCH), .WIDTH(A_W), .HEIGHT(A_H)) dut_a (
    .clk(clk), .resetn(resetn), .valid_in(a_valid), .data_in(a_data),
    .relu_en(a_relu), .frame_clr(a_clr), .data_out(a_dout),
    .valid_out(a_vout), .done(a_done)
  );

  // ---------------- DUT B ----------------
  logic                   b_valid, b_relu, b_clr;
  logic [B_NCH*B_DW-1:0]  b_data;
  logic [B_NCH*B_DW-1:0]  b_dout;
  logic                   b_vout, b_done;

  relu_maxpool_nch dut_b (
    .clk(clk), .resetn(resetn), .valid_in(b_valid), .data_in(b_data),
    .relu_en(b_relu), .frame_clr(b_clr), .data_out(b_dout),
    .valid_out(b_vout), .done(b_done)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Observed output pulses (for literal expectations).
  logic [A_DW-1:0] obs_a0[$];
  logic [A_DW-1:0] obs_a1[$];
  logic            obs_adone[$];
  logic [B_DW-1:0] obs_b0[$];
  logic [B_DW-1:0] obs_b7[$];
  logic            obs_bdone[$];

  // ---------------- behavioural model ----------------
  // Stores the whole ReLU'd image; a window's result is the max of its four
  // stored pixels, produced on the cycle after its bottom-right pixel.
  int m_col[2];
  int m_row[2];
  int img[2][16][16][8];
  int exp_d[2][8];
  bit exp_v[2];
  bit exp_dn[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_col[k] = 0; m_row[k] = 0; exp_v[k] = 0; exp_dn[k] = 0;
      for (int c = 0; c < 8; c++) exp_d[k][c] = 0;
    end
  endtask

  task automatic model_step(input int k, input int w, input int h, input int nch,
                            input bit valid, input bit clr, input bit relu, input int px[8]);
    int v, r, q, mx;
    exp_v[k] = 0;
    exp_dn[k] = 0;
    if (clr) begin
      m_col[k] = 0;
      m_row[k] = 0;
    end else if (valid) begin
      r = m_row[k];
      q = m_col[k];
      for (int c = 0; c < nch; c++) begin
        v = px[c];
        if (relu && v < 0) v = 0;
        img[k][r][q][c] = v;
      end
      if (r % 2 == 1 && q % 2 == 1) begin
        for (int c = 0; c < nch; c++) begin
          mx = img[k][r-1][q-1][c];
          if (img[k][r-1][q][c] > mx) mx = img[k][r-1][q][c];
          if (img[k][r][q-1][c] > mx) mx = img[k][r][q-1][c];
          if (img[k][r][q][c] > mx)   mx = img[k][r][q][c];
          exp_d[k][c] = mx;
        end
        exp_v[k] = 1;
        exp_dn[k] = (r == h - 1) && (q == w - 1);
      end
      if (q == w - 1) begin
        m_col[k] = 0;
        m_row[k] = (r == h - 1) ? 0 : r + 1;
      end else begin
        m_col[k] = q + 1;
      end
    end
  endtask

  // ---------------- compare process (falling edge) ----------------
  // Inputs change at posedge+1, so at the falling edge they are the values
  // the next rising edge will sample.
  always @(negedge clk) begin
    int px[8];
    if (!resetn) begin
      check("rst_a_valid", a_vout, 0);
      check("rst_a_done", a_done, 0);
      check("rst_a_data", a_dout, 0);
      check("rst_b_valid", b_vout, 0);
      check("rst_b_done", b_done, 0);
      for (int c = 0; c < B_NCH; c++) check("rst_b_data", b_dout[c*B_DW +: B_DW], 0);
      model_reset();
    end else begin
      check("a_valid_out", a_vout, exp_v[0]);
      check("a_done", a_done, exp_dn[0]);
      for (int c = 0; c < A_NCH; c++)
        check($sformatf("a_data_ch%0d", c), a_dout[c*A_DW +: A_DW], exp_d[0][c][15:0]);
      check("b_valid_out", b_vout, exp_v[1]);
      check("b_done", b_done, exp_dn[1]);
      for (int c = 0; c < B_NCH; c++)
        check($sformatf("b_data_ch%0d", c), b_dout[c*B_DW +: B_DW], exp_d[1][c]);

      if (a_vout) begin
        obs_a0.push_back(a_dout[15:0]);
        obs_a1.push_back(a_dout[31:16]);
        obs_adone.push_back(a_done);
      end
      if (b_vout) begin
        obs_b0.push_back(b_dout[31:0]);
        obs_b7.push_back(b_dout[255:224]);
        obs_bdone.push_back(b_done);
      end

      for (int c = 0; c < 8; c++) px[c] = 0;
      for (int c = 0; c < A_NCH; c++) px[c] = int'($signed(a_data[c*A_DW +: A_DW]));
      model_step(0, A_W, A_H, A_NCH, a_valid, a_clr, a_relu, px);
      for (int c = 0; c < B_NCH; c++) px[c] = int'($signed(b_data[c*B_DW +: B_DW]));
      model_step(1, B_W, B_H, B_NCH, b_valid, b_clr, b_relu, px);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_a(input bit v, input int c0, input int c1, input bit relu, input bit clr);
    @(posedge clk);
    #1;
    a_valid = v;
    a_data  = {c1[15:0], c0[15:0]};
    a_relu  = relu;
    a_clr   = clr;
  endtask

  task automatic idle_a(input int n);
    repeat (n) drive_a(0, 0, 0, 1, 0);
  endtask

  task automatic clear_obs();
    @(posedge clk);
    #1;
    obs_a0.delete(); obs_a1.delete(); obs_adone.delete();
    obs_b0.delete(); obs_b7.delete(); obs_bdone.delete();
  endtask

  // ch0 = 1..16 in raster order, ch1 constant.
  task automatic frame_a(input bit gaps, input bit relu, input int c1);
    for (int p = 1; p <= 16; p++) begin
      drive_a(1, p, c1, relu, 0);
      if (gaps) drive_a(0, 0, 0, relu, 0);
    end
    idle_a(3);
  endtask

  // Literal expectations for a ch0 = 1..16 frame.
  task automatic chk_std(input string tag);
    int ev[4];
    bit ed[4];
    ev = '{6, 8, 14, 16};
    ed = '{0, 0, 0, 1};
    check({tag, "_count"}, obs_a0.size(), 4);
    for (int i = 0; i < obs_a0.size() && i < 4; i++) begin
      check($sformatf("%s_val%0d", tag, i), obs_a0[i], ev[i]);
      check($sformatf("%s_done%0d", tag, i), obs_adone[i], ed[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int win[16];
    int dpos[$];
    a_valid = 0; a_data = '0; a_relu = 1; a_clr = 0;
    b_valid = 0; b_data = '0; b_relu = 1; b_clr = 0;

    #1 resetn = 0;
    #1;
    check("reset_a_data", a_dout, 0);
    check("reset_a_valid", a_vout, 0);
    check("reset_a_done", a_done, 0);
    check("reset_b_data", b_dout[31:0], 0);
    repeat (3) @(posedge clk);
    #3 resetn = 1;
    idle_a(2);

    // Test 1: basic pooling
    clear_obs();
    frame_a(0, 1, -9);
    chk_std("t1");
    for (int i = 0; i < obs_a1.size(); i++) check("t1_ch1_relu", obs_a1[i], 0);

    // Test 2: ReLU modes
    clear_obs();
    frame_a(0, 1, -5);
    check("t2a_count", obs_a1.size(), 4);
    for (int i = 0; i < obs_a1.size(); i++) check("t2a_ch1", obs_a1[i], 16'h0000);
    clear_obs();
    frame_a(0, 0, -5);
    check("t2b_count", obs_a1.size(), 4);
    for (int i = 0; i < obs_a1.size(); i++) check("t2b_ch1", obs_a1[i], 16'hFFFB);
    clear_obs();
    win = '{-3, -1, 0, 0, -7, -2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int p = 0; p < 16; p++) drive_a(1, p + 1, win[p], 0, 0);
    idle_a(3);
    check("t2c_count", obs_a1.size(), 4);
    if (obs_a1.size() > 0) check("t2c_neg_window", obs_a1[0], 16'hFFFF);

    // Test 3: input gaps
    clear_obs();
    frame_a(1, 1, 0);
    chk_std("t3");

    // Test 4: frame restart (clr with valid wins, pixel dropped)
    for (int p = 0; p < 6; p++) drive_a(1, 50 + p, 0, 1, 0);
    drive_a(1, 99, 0, 1, 1);
    idle_a(1);
    obs_a0.delete(); obs_a1.delete(); obs_adone.delete();
    frame_a(0, 1, 0);
    chk_std("t4");

    // Test 5: asynchronous reset mid-frame
    for (int p = 1; p <= 7; p++) drive_a(1, p, 0, 1, 0);
    @(posedge clk);
    #1 a_valid = 0;
    #1 resetn = 0;
    #1;
    check("t5_async_data", a_dout, 0);
    check("t5_async_valid", a_vout, 0);
    check("t5_async_done", a_done, 0);
    repeat (2) @(posedge clk);
    #3 resetn = 1;
    clear_obs();
    frame_a(0, 1, 0);
    chk_std("t5");

    // Test 6: back-to-back default-size frames
    clear_obs();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 256; i++) begin
        @(posedge clk);
        #1;
        b_valid = 1;
        for (int c = 0; c < B_NCH; c++) b_data[c*B_DW +: B_DW] = i + c;
      end
    end
    @(posedge clk);
    #1 b_valid = 0;
    repeat (3) @(posedge clk);
    check("t6_pulses", obs_b0.size(), 128);
    if (obs_b0.size() == 128) begin
      check("t6_f0_first_ch0", obs_b0[0], 17);
      check("t6_f0_last_ch0", obs_b0[63], 255);
      check("t6_f1_first_ch0", obs_b0[64], 17);
      check("t6_f1_last_ch0", obs_b0[127], 255);
      check("t6_f0_first_ch7", obs_b7[0], 24);
      check("t6_f1_last_ch7", obs_b7[127], 262);
    end
    for (int i = 0; i < obs_bdone.size(); i++) if (obs_bdone[i]) dpos.push_back(i);
    check("t6_done_count", dpos.size(), 2);
    if (dpos.size() == 2) begin
      check("t6_done_pos0", dpos[0], 63);
      check("t6_done_pos1", dpos[1], 127);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
